pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Job-level controller that sequences 64-bit pattern detection over a 32-bit word stream. A host programs a pattern, a word count and a hit limit through a config handshake. The block then streams words through an internal 96-bit sliding window, reports each match with word index and bit offset through a hit handshake, and closes each job with a done status. It sits between the stream source and the match-consumer logic, and owns all start, stop and backpressure decisions for the detection datapath.

## Interface
- DATA_W, 32, stream word width (fixed; the window is 3×DATA_W)
- PAT_W, 64, pattern width
- CNT_W, 16, width of length, hit-count and index fields
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_valid / cfg_ready  in / out  1  job-start handshake
- cfg_pattern  in  PAT_W  pattern to match
- cfg_len  in  CNT_W  number of words in the job
- cfg_max_hits  in  CNT_W  hit limit; 0 means unlimited
- abort  in  1  terminate the current job
- in_valid / in_ready  in / out  1  stream handshake
- in_data  in  DATA_W  stream word; the newest word enters the window LSBs
- hit_valid / hit_ready  out / in  1  match-report handshake
- hit_word_idx  out  CNT_W  0-based index of the word that completed the match
- hit_bit_off  out  5  offset i of the match; bits [i+63:i] of the window
- done_valid  out  1  one-cycle job-complete pulse
- done_hits  out  CNT_W  hits reported in the job
- done_status  out  2  0 COMPLETE, 1 LIMIT, 2 ABORT

## Operation
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE
  - cfg_ready=1.
  - On cfg_valid, latch the config, clear the window and counters, then go to SCAN.
  - If cfg_len=0, go directly to DONE with status COMPLETE.
- SCAN
  - in_ready = !hit_valid && words_left>0.
  - On accept: window <= {window[63:0], in_data}; increment word_idx.
- Compare
  - Checks offsets 0..31 only, so each alignment is tested exactly once across words.
  - Lowest matching offset wins. A word produces at most one hit.
- Validity gating
  - No hit for word 0.
  - For word 1, offset 0 only.
  - From word 2 onward, all offsets.
  - Zero-filled window bits never produce a match.
- Hit reporting
  - The compare result is registered and drives hit_valid.
  - hit fields are held stable until hit_ready.
  - The hit counter increments on the hit handshake.
- SCAN → FLUSH once the last word is accepted. FLUSH waits for the final compare and for any pending hit to drain.
- LIMIT: when the hit count reaches cfg_max_hits (≠0) on a handshake, go to DONE with status LIMIT. No further words are accepted.
- ABORT: in SCAN or FLUSH, abort=1 drops any pending hit and goes to DONE with status ABORT. abort is ignored in IDLE. If abort and cfg_valid arrive together in IDLE, the config is accepted.
- DONE: done_valid=1 for one cycle with done_hits and done_status, then back to IDLE.

## Timing
- Reset: every output is 0 while rst_n=0. cfg_ready=1 in the first cycle after release.
- Config to stream: a config accepted at edge E gives in_ready=1 from E+1 (if cfg_len>0). A cfg_len=0 job gives done_valid in cycle E+1.
- Stream to hit: a word accepted at edge E updates the window at E. hit_valid is asserted at E+1.
- in_ready is low in cycle E+1 only if that word hits. Sustained throughput is 1 word/cycle without hits, and a hit costs at least one stall cycle.
- Hit to limit: a hit handshake at edge H that reaches the limit gives done_valid in cycle H+1.
- Last word to done: last word accepted at E, no hit, gives done_valid at E+2.
- Abort: abort sampled at edge A drops hit_valid and raises done_valid in cycle A+1.
- Reset mid-job returns the block to IDLE. Nothing is reported for the interrupted job.

## Structure
- pattern_scan_pkg holds:
  - the state enum: IDLE, SCAN, FLUSH, DONE
  - the status enum: COMPLETE, LIMIT, ABORT
  - DATA_W, PAT_W, CNT_W and WIN_W = 3*DATA_W
- The sub-module pattern_window_cmp holds the 96-bit window register, the 32-offset compare with validity mask, and the lowest-offset priority encode. It has a registered hit/offset output.
- The FSM, counters and handshakes live in pattern_scan_ctrl.

## Test plan
- Aligned match: pattern 0xDEADBEEFCAFEBABE, len 4, words 0x11111111, 0xDEADBEEF, 0xCAFEBABE, 0x0 → one hit, idx 2, off 0; done hits=1, status COMPLETE.
- Unaligned match: words 0x00DEADBE, 0xEFCAFEBA, 0xBE000000 (len 3) → one hit, idx 2, off 24.
- Limit: max_hits=1, len 6, pattern at words 1–2 and 3–4 → one hit; in_ready stays low afterwards; status LIMIT, hits=1.
- Backpressure: hit_ready held low 5 cycles → hit fields stable and in_ready=0 throughout; hit releases one cycle after hit_ready=1, and no hit is lost.
- Abort mid-scan after one reported hit → done_valid next cycle with hits=1, status ABORT; a new config is accepted the cycle after.
- Edges:
  - cfg_len=0 → done_valid at E+1 with hits=0.
  - All-zero pattern over zero words → no hits on words 0–1.
  - rst_n low mid-job → all outputs 0, then IDLE.

Source files
------------

// File: rtl/pattern_scan_pkg.sv
// Shared widths and enumerations for the pattern scan controller and its window/compare datapath.
package pattern_scan_pkg;
  localparam int DATA_W = 32;
  localparam int PAT_W  = 64;
  localparam int CNT_W  = 16;
  localparam int WIN_W  = 3 * DATA_W;
  localparam int N_OFF  = DATA_W;
  localparam int OFF_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COMPLETE = 2'd0,
    LIMIT    = 2'd1,
    ABORT    = 2'd2
  } status_t;
endpackage

// File: rtl/pattern_scan_if.sv
// Config, stream, hit-report and done signals of the pattern scan controller.
interface pattern_scan_if;
  import pattern_scan_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [CNT_W-1:0]  cfg_len;
  logic [CNT_W-1:0]  cfg_max_hits;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              hit_valid;
  logic              hit_ready;
  logic [CNT_W-1:0]  hit_word_idx;
  logic [OFF_W-1:0]  hit_bit_off;
  logic              done_valid;
  logic [CNT_W-1:0]  done_hits;
  logic [1:0]        done_status;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_max_hits, abort,
    output in_valid, in_data, hit_ready,
    input  cfg_ready, in_ready, hit_valid, hit_word_idx, hit_bit_off,
    input  done_valid, done_hits, done_status
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_max_hits, abort,
    input  in_valid, in_data, hit_ready,
    output cfg_ready, in_ready, hit_valid, hit_word_idx, hit_bit_off,
    output done_valid, done_hits, done_status
  );
endinterface

// File: rtl/pattern_window_cmp.sv
// Sliding word window, 32-offset pattern compare with fill-based validity mask,
// lowest-offset priority encode and registered hit/offset.
module pattern_window_cmp
  import pattern_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              hit_clr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PAT_W-1:0]  pattern,
  output logic              hit,
  output logic [OFF_W-1:0]  hit_off
);
  // Window bit 95 never reaches a compare at offsets 0..31, so only 95 bits exist.
  logic [WIN_W-DATA_W-2:0] hist_q;
  logic [WIN_W-2:0]        window;
  logic [1:0]              fill_q;
  logic [N_OFF-1:0]        mask;
  logic                    match_any;
  logic [OFF_W-1:0]        match_off;

  assign window = {hist_q, in_data};

  always_comb begin
    case (fill_q)
      2'd0:    mask = '0;
      2'd1:    mask = {{(N_OFF-1){1'b0}}, 1'b1};
      default: mask = '1;
    endcase
  end

  always_comb begin
    match_any = 1'b0;
    match_off = '0;
    for (int i = N_OFF - 1; i >= 0; i--) begin
      if (mask[i] && (window[i +: PAT_W] == pattern)) begin
        match_any = 1'b1;
        match_off = OFF_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hist_q  <= '0;
      fill_q  <= '0;
      hit     <= 1'b0;
      hit_off <= '0;
    end else begin
      if (accept) begin
        hist_q <= window[WIN_W-DATA_W-2:0];
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      end
      if (hit_clr) begin
        hit <= 1'b0;
      end else if (accept) begin
        hit     <= match_any;
        hit_off <= match_off;
      end
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job sequencer for 64-bit pattern detection over a 32-bit stream: config capture,
// stream backpressure, hit reporting, hit limit, abort and done status.
//
//   state | meaning
//   IDLE  | cfg_ready high, waiting for a job
//   SCAN  | accepting words while no hit is pending
//   FLUSH | all words taken, draining the final compare / pending hit
//   DONE  | one-cycle done pulse with hit count and status
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pattern_scan_if.slave  bus
);
  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] max_q, left_q, idx_q, cnt_q, hit_idx_q;
  logic             hit_q;
  logic [OFF_W-1:0] hit_off_q;
  logic             cfg_take, in_rdy, accept, hit_hs, limit_hs, abort_act;

  assign cfg_take  = (state_q == IDLE) && bus.cfg_valid;
  assign in_rdy    = (state_q == SCAN) && !hit_q && (left_q != '0);
  assign accept    = in_rdy && bus.in_valid;
  assign hit_hs    = hit_q && bus.hit_ready;
  assign abort_act = bus.abort && ((state_q == SCAN) || (state_q == FLUSH));
  assign limit_hs  = hit_hs && (max_q != '0) && ((cnt_q + CNT_W'(1)) == max_q);

  pattern_window_cmp u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cfg_take),
    .accept  (accept),
    .hit_clr (hit_hs || abort_act),
    .in_data (bus.in_data),
    .pattern (pat_q),
    .hit     (hit_q),
    .hit_off (hit_off_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= COMPLETE;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          status_d = COMPLETE;
          state_d  = (bus.cfg_len == '0) ? DONE : SCAN;
        end
      end
      SCAN, FLUSH: begin
        if (bus.abort) begin
          state_d  = DONE;
          status_d = ABORT;
        end else if (limit_hs) begin
          state_d  = DONE;
          status_d = LIMIT;
        end else if (state_q == SCAN) begin
          if (accept && (left_q == CNT_W'(1))) state_d = FLUSH;
        end else if (hit_hs || !hit_q) begin
          state_d  = DONE;
          status_d = COMPLETE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Abort discards a pending hit, so it must not be counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q     <= '0;
      max_q     <= '0;
      left_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      hit_idx_q <= '0;
    end else begin
      if (cfg_take) begin
        pat_q  <= bus.cfg_pattern;
        max_q  <= bus.cfg_max_hits;
        left_q <= bus.cfg_len;
        idx_q  <= '0;
        cnt_q  <= '0;
      end
      if (accept) begin
        left_q    <= left_q - CNT_W'(1);
        idx_q     <= idx_q + CNT_W'(1);
        hit_idx_q <= idx_q;
      end
      if (hit_hs && !abort_act) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.cfg_ready    = 1'b0;
    bus.in_ready     = 1'b0;
    bus.hit_valid    = 1'b0;
    bus.hit_word_idx = '0;
    bus.hit_bit_off  = '0;
    bus.done_valid   = 1'b0;
    bus.done_hits    = '0;
    bus.done_status  = '0;
    if (rst_n) begin
      bus.cfg_ready = (state_q == IDLE);
      bus.in_ready  = in_rdy;
      bus.hit_valid = hit_q;
      if (hit_q) begin
        bus.hit_word_idx = hit_idx_q;
        bus.hit_bit_off  = hit_off_q;
      end
      if (state_q == DONE) begin
        bus.done_valid  = 1'b1;
        bus.done_hits   = cnt_q;
        bus.done_status = status_q;
      end
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: matches, limit, backpressure, abort, reset.
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  localparam logic [PAT_W-1:0] PAT = 64'hDEADBEEFCAFEBABE;

  logic clk = 1'b0;
  logic rst_n;
  pattern_scan_if bus();

  pattern_scan_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0, nh = 0, n_acc = 0, n_done = 0, hs_cyc = 0, done_cyc = 0;
  int hit_base = 0, acc_base = 0, done_base = 0;
  logic [CNT_W-1:0]  hit_idx_log [32];
  logic [OFF_W-1:0]  hit_off_log [32];
  logic [CNT_W-1:0]  d_hits;
  logic [1:0]        d_status;
  logic [DATA_W-1:0] wq [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.hit_valid && bus.hit_ready) begin
        hit_idx_log[nh % 32] = bus.hit_word_idx;
        hit_off_log[nh % 32] = bus.hit_bit_off;
        nh = nh + 1;
        hs_cyc = cyc;
      end
      if (bus.in_valid && bus.in_ready) n_acc = n_acc + 1;
      if (bus.done_valid) begin
        d_hits   = bus.done_hits;
        d_status = bus.done_status;
        done_cyc = cyc;
        n_done   = n_done + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [PAT_W-1:0] pat, input int len, input int max_hits);
    int budget;
    budget = 0;
    while (!bus.cfg_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!bus.cfg_ready) begin
      errors++;
      checks++;
      $display("FAIL cfg_ready_timeout: cfg_ready=%0b required 1", bus.cfg_ready);
    end
    bus.cfg_pattern  = pat;
    bus.cfg_len      = CNT_W'(len);
    bus.cfg_max_hits = CNT_W'(max_hits);
    bus.cfg_valid    = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    hit_base  = nh;
    acc_base  = n_acc;
    done_base = n_done;
  endtask

  task automatic feed(input int first, input int n);
    int  budget;
    bit  stop;
    stop = 1'b0;
    for (int k = first; k < first + n && !stop; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = wq[k];
      budget = 0;
      while (!bus.in_ready && n_done == done_base && budget < 40) begin
        tick();
        budget++;
      end
      if (bus.in_ready) begin
        tick();
      end else begin
        stop = 1'b1;
        if (budget >= 40) begin
          errors++;
          checks++;
          $display("FAIL feed_timeout: word %0d not accepted after %0d cycles", k, budget);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (n_done == done_base && budget < 40) begin
      tick();
      budget++;
    end
    if (n_done == done_base) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: no done_valid within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    logic [60:0] outs;
    rst_n = 1'b0;
    repeat (3) tick();
    outs = {bus.cfg_ready, bus.in_ready, bus.hit_valid, bus.hit_word_idx, bus.hit_bit_off,
            bus.done_valid, bus.done_hits, bus.done_status};
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
    checks++;
    rst_n = 1'b1;
    tick();
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0b required 1", bus.cfg_ready); end
    checks++;
    if ({bus.in_ready, bus.hit_valid, bus.done_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_idle_outs: got %b required 000", {bus.in_ready, bus.hit_valid, bus.done_valid});
    end
    checks++;
  endtask

  task automatic test_aligned();
    bus.hit_ready = 1'b1;
    wq = '{32'h11111111, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(PAT, 4, 0);
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL aligned_in_ready: got %0b required 1", bus.in_ready); end
    checks++;
    feed(0, 4);
    if (bus.done_valid !== 1'b0) begin errors++; $display("FAIL aligned_done_early: got %0b required 0", bus.done_valid); end
    checks++;
    tick();
    if ({bus.done_valid, bus.done_hits, bus.done_status} !== {1'b1, 16'd1, 2'd0}) begin
      errors++; $display("FAIL aligned_done: got v=%0b hits=%0d st=%0d required v=1 hits=1 st=0",
                         bus.done_valid, bus.done_hits, bus.done_status);
    end
    checks++;
    tick();
    if (nh - hit_base !== 1) begin errors++; $display("FAIL aligned_hit_count: got %0d required 1", nh - hit_base); end
    checks++;
    if ({hit_idx_log[hit_base % 32], hit_off_log[hit_base % 32]} !== {16'd2, 5'd0}) begin
      errors++; $display("FAIL aligned_hit_fields: got idx=%0d off=%0d required idx=2 off=0",
                         hit_idx_log[hit_base % 32], hit_off_log[hit_base % 32]);
    end
    checks++;
  endtask

  task automatic test_unaligned();
    bus.hit_ready = 1'b1;
    wq = '{32'h00DEADBE, 32'hEFCAFEBA, 32'hBE000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(PAT, 3, 0);
    feed(0, 3);
    wait_done();
    if (nh - hit_base !== 1) begin errors++; $display("FAIL unaligned_hit_count: got %0d required 1", nh - hit_base); end
    checks++;
    if ({hit_idx_log[hit_base % 32], hit_off_log[hit_base % 32]} !== {16'd2, 5'd24}) begin
      errors++; $display("FAIL unaligned_hit_fields: got idx=%0d off=%0d required idx=2 off=24",
                         hit_idx_log[hit_base % 32], hit_off_log[hit_base % 32]);
    end
    checks++;
    if ({d_hits, d_status} !== {16'd1, 2'd0}) begin
      errors++; $display("FAIL unaligned_done: got hits=%0d st=%0d required hits=1 st=0", d_hits, d_status);
    end
    checks++;
  endtask

  task automatic test_limit();
    bus.hit_ready = 1'b1;
    wq = '{32'h0, 32'hDEADBEEF, 32'hCAFEBABE, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0};
    start_job(PAT, 6, 1);
    feed(0, 6);
    wait_done();
    if (nh - hit_base !== 1) begin errors++; $display("FAIL limit_hit_count: got %0d required 1", nh - hit_base); end
    checks++;
    if (n_acc - acc_base !== 3) begin errors++; $display("FAIL limit_words_taken: got %0d required 3", n_acc - acc_base); end
    checks++;
    if ({d_hits, d_status} !== {16'd1, 2'd1}) begin
      errors++; $display("FAIL limit_done: got hits=%0d st=%0d required hits=1 st=1", d_hits, d_status);
    end
    checks++;
    if (done_cyc !== hs_cyc + 1) begin
      errors++; $display("FAIL limit_latency: got done at %0d required %0d", done_cyc, hs_cyc + 1);
    end
    checks++;
  endtask

  task automatic test_backpressure();
    bus.hit_ready = 1'b0;
    wq = '{32'h11111111, 32'hDEADBEEF, 32'hCAFEBABE, 32'h22222222, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(PAT, 4, 0);
    feed(0, 3);
    for (int c = 0; c < 5; c++) begin
      if ({bus.hit_valid, bus.hit_word_idx, bus.hit_bit_off, bus.in_ready} !== {1'b1, 16'd2, 5'd0, 1'b0}) begin
        errors++; $display("FAIL bp_hold_c%0d: got v=%0b idx=%0d off=%0d rdy=%0b required v=1 idx=2 off=0 rdy=0",
                           c, bus.hit_valid, bus.hit_word_idx, bus.hit_bit_off, bus.in_ready);
      end
      checks++;
      tick();
    end
    bus.hit_ready = 1'b1;
    #1;
    if (bus.hit_valid !== 1'b1) begin errors++; $display("FAIL bp_before_release: got %0b required 1", bus.hit_valid); end
    checks++;
    tick();
    if ({bus.hit_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release: got v=%0b rdy=%0b required v=0 rdy=1", bus.hit_valid, bus.in_ready);
    end
    checks++;
    feed(3, 1);
    wait_done();
    if ({nh - hit_base, d_hits, d_status} !== {32'd1, 16'd1, 2'd0}) begin
      errors++; $display("FAIL bp_done: got seen=%0d hits=%0d st=%0d required seen=1 hits=1 st=0",
                         nh - hit_base, d_hits, d_status);
    end
    checks++;
  endtask

  task automatic test_abort();
    bus.hit_ready = 1'b1;
    wq = '{32'h0, 32'hDEADBEEF, 32'hCAFEBABE, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    start_job(PAT, 8, 0);
    feed(0, 4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    if ({bus.done_valid, bus.done_hits, bus.done_status} !== {1'b1, 16'd1, 2'd2}) begin
      errors++; $display("FAIL abort_done: got v=%0b hits=%0d st=%0d required v=1 hits=1 st=2",
                         bus.done_valid, bus.done_hits, bus.done_status);
    end
    checks++;
    tick();
    if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_cfg_ready: got %0b required 1", bus.cfg_ready); end
    checks++;
    bus.hit_ready = 1'b0;
    start_job(PAT, 8, 0);
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_new_job: in_ready=%0b required 1", bus.in_ready); end
    checks++;
    feed(0, 3);
    if (bus.hit_valid !== 1'b1) begin errors++; $display("FAIL abort_pending: hit_valid=%0b required 1", bus.hit_valid); end
    checks++;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    if ({bus.hit_valid, bus.done_valid, bus.done_hits, bus.done_status} !== {1'b0, 1'b1, 16'd0, 2'd2}) begin
      errors++; $display("FAIL abort_drop_hit: got hv=%0b dv=%0b hits=%0d st=%0d required hv=0 dv=1 hits=0 st=2",
                         bus.hit_valid, bus.done_valid, bus.done_hits, bus.done_status);
    end
    checks++;
    tick();
    bus.hit_ready = 1'b1;
  endtask

  task automatic test_len_zero();
    bus.abort = 1'b1;
    tick();
    if ({bus.cfg_ready, bus.done_valid} !== 2'b10) begin
      errors++; $display("FAIL idle_abort_ignored: got rdy=%0b dv=%0b required rdy=1 dv=0", bus.cfg_ready, bus.done_valid);
    end
    checks++;
    start_job(PAT, 0, 0);
    bus.abort = 1'b0;
    if ({bus.done_valid, bus.done_hits, bus.done_status} !== {1'b1, 16'd0, 2'd0}) begin
      errors++; $display("FAIL len_zero_done: got v=%0b hits=%0d st=%0d required v=1 hits=0 st=0",
                         bus.done_valid, bus.done_hits, bus.done_status);
    end
    checks++;
    tick();
  endtask

  task automatic test_zero_fill();
    bus.hit_ready = 1'b1;
    wq = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(64'h0, 1, 0);
    feed(0, 1);
    wait_done();
    if ({nh - hit_base, d_hits, d_status} !== {32'd0, 16'd0, 2'd0}) begin
      errors++; $display("FAIL zero_word0: got seen=%0d hits=%0d st=%0d required 0 0 0", nh - hit_base, d_hits, d_status);
    end
    checks++;
    wq = '{32'hABCD1234, 32'hABCD5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(64'h0000ABCD1234ABCD, 3, 0);
    feed(0, 3);
    wait_done();
    if ({nh - hit_base, d_hits} !== {32'd0, 16'd0}) begin
      errors++; $display("FAIL zero_fill_word1: got seen=%0d hits=%0d required 0 0", nh - hit_base, d_hits);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [60:0] outs;
    bus.hit_ready = 1'b0;
    wq = '{32'h11111111, 32'hDEADBEEF, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_job(PAT, 6, 0);
    feed(0, 3);
    rst_n = 1'b0;
    #1;
    outs = {bus.cfg_ready, bus.in_ready, bus.hit_valid, bus.hit_word_idx, bus.hit_bit_off,
            bus.done_valid, bus.done_hits, bus.done_status};
    if (outs !== '0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", outs); end
    checks++;
    tick();
    rst_n = 1'b1;
    bus.hit_ready = 1'b1;
    #1;
    if ({bus.cfg_ready, bus.hit_valid, bus.in_ready} !== 3'b100) begin
      errors++; $display("FAIL midreset_idle: got rdy=%0b hv=%0b ir=%0b required 1 0 0",
                         bus.cfg_ready, bus.hit_valid, bus.in_ready);
    end
    checks++;
    repeat (3) tick();
    if (n_done !== done_base) begin errors++; $display("FAIL midreset_no_done: got %0d dones required 0", n_done - done_base); end
    checks++;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_pattern  = '0;
    bus.cfg_len      = '0;
    bus.cfg_max_hits = '0;
    bus.abort        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.hit_ready    = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_limit();
    test_backpressure();
    test_abort();
    test_len_zero();
    test_zero_fill();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
